// File: rtl/fifo_rr_arb_if.sv
// fifo_rr_arb_if: bundle between NCH FWFT FIFO read ports, the arbiter and the downstream sink
// Ports: empty/din (FIFO heads), rd_en (pops), dout/dout_ch/dout_vld/dout_rdy (output handshake), busy
// master = arbiter side, slave = FIFO/sink side
interface fifo_rr_arb_if #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int CHW = 2
);
  logic [NCH-1:0]    empty;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    rd_en;
  logic [DW-1:0]     dout;
  logic [CHW-1:0]    dout_ch;
  logic              dout_vld;
  logic              dout_rdy;
  logic              busy;
  modport master (input empty, din, dout_rdy, output rd_en, dout, dout_ch, dout_vld, busy);
  modport slave (output empty, din, dout_rdy, input rd_en, dout, dout_ch, dout_vld, busy);
endinterface

// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: round-robin arbiter draining up to BURST words per grant from NCH FWFT FIFOs
// Ports: clk, rst (async active-high), bus (fifo_rr_arb_if.master: empty, din, rd_en, dout, dout_ch,
//        dout_vld, dout_rdy, busy)
module fifo_rr_arb #(
  parameter int DW    = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int BURST = 4
) (
  input logic           clk,
  input logic           rst,
  fifo_rr_arb_if.master bus
);
  if (NCH < 2 || NCH > 16 || (1 << CHW) < NCH) begin : g_bad_nch
    $fatal(1, "fifo_rr_arb: illegal NCH=%0d / CHW=%0d", NCH, CHW);
  end
  if (BURST < 1 || BURST > 255) begin : g_bad_burst
    $fatal(1, "fifo_rr_arb: illegal BURST=%0d", BURST);
  end
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t         state, nxt_state;
  logic [CHW-1:0] grant, last, pick, hi, lo;
  logic [7:0]     cnt;
  logic           acc, pop, any, done, fh;
  logic [DW-1:0]  words [NCH];
  for (genvar i = 0; i < NCH; i++) begin : g_w
    assign words[i] = bus.din[i*DW +: DW];
  end
  assign acc       = !bus.dout_vld || bus.dout_rdy;
  assign pop       = state == S_BURST && !bus.empty[grant] && acc;
  assign bus.rd_en = NCH'(pop) << grant;
  assign bus.busy  = state == S_BURST;
  assign any       = ~&bus.empty;
  // a stalled output (acc==0) freezes the burst regardless of empty
  assign done      = (pop && cnt == 8'(BURST - 1)) || (acc && bus.empty[grant]);
  // cyclic search from last+1: lowest non-empty above last, else lowest non-empty overall
  always_comb begin
    hi = '0;
    lo = last;
    fh = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!bus.empty[i]) begin
        if (CHW'(i) > last) begin
          hi = CHW'(i);
          fh = 1'b1;
        end
        lo = CHW'(i);
      end
    end
    pick = fh ? hi : lo;
  end
  always_comb begin
    nxt_state = state;
    nxt_state = state == S_IDLE ? (any ? S_BURST : S_IDLE) : (done ? S_IDLE : S_BURST);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      last         <= CHW'(NCH - 1);
      cnt          <= '0;
      bus.dout     <= '0;
      bus.dout_ch  <= '0;
      bus.dout_vld <= 1'b0;
    end else begin
      if (state == S_IDLE && any) begin
        grant <= pick;
        cnt   <= '0;
      end
      if (pop) cnt <= cnt + 8'd1;
      if (state == S_BURST && done) last <= grant;
      if (acc) bus.dout_vld <= pop;
      if (pop) begin
        bus.dout    <= words[grant];
        bus.dout_ch <= grant;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_arb.sv
// tb_fifo_rr_arb: scoreboard bench for fifo_rr_arb with modelled FWFT FIFOs
module tb_fifo_rr_arb;
  localparam int DW = 8, NCH = 4, CHW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_rr_arb_if #(.DW(DW), .NCH(NCH), .CHW(CHW)) bus ();
  fifo_rr_arb #(.DW(DW), .NCH(NCH), .CHW(CHW), .BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] fq [NCH][$];
  logic [DW-1:0] xq [NCH][$];
  int och [$];
  int hs_cyc [$];
  int tests = 0, fails = 0, cyc = 0;
  logic [NCH-1:0] rd_s = '0;
  logic [DW-1:0] e_w;
  int e_c;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic load(input int ch, input logic [DW-1:0] d);
    fq[ch].push_back(d);
    xq[ch].push_back(d);
  endtask
  task automatic chk_rst_out(input string nm);
    chk(nm, {16'd0, bus.dout, bus.dout_ch, bus.dout_vld, bus.rd_en, bus.busy}, 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NCH; i++) begin
      fq[i].delete();
      xq[i].delete();
    end
    och.delete();
    hs_cyc.delete();
    chk_rst_out("rst_out_a");
    @(negedge clk);
    #1;
    chk_rst_out("rst_out_b");
    rst = 1'b0;
  endtask
  task automatic wait_drain(input int limit);
    int n, t;
    n = 0;
    t = 1;
    while (t != 0 && n < limit) begin
      @(negedge clk);
      n++;
      t = int'(bus.dout_vld) + int'(bus.busy);
      for (int i = 0; i < NCH; i++) t += fq[i].size();
    end
    chk("drain_timeout", n >= limit, 0);
  endtask
  task automatic chk_sb(input string nm);
    int t;
    t = och.size();
    for (int i = 0; i < NCH; i++) t += xq[i].size();
    chk(nm, t, 0);
  endtask
  task automatic wait_hs(input int k);
    int n;
    n = 0;
    while (hs_cyc.size() < k && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_hs_timeout", n >= 50, 0);
  endtask
  // FIFO pops at the edge, using rd_en sampled late in the previous cycle
  always @(posedge clk) begin
    cyc++;
    if (!rst)
      for (int i = 0; i < NCH; i++)
        if (rd_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
  end
  // refresh FIFO heads, then monitor rd_en legality and output handshakes
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      bus.empty[i] = fq[i].size() == 0;
      bus.din[i*DW +: DW] = fq[i].size() == 0 ? '0 : fq[i][0];
    end
    #1;
    rd_s = rst ? '0 : bus.rd_en;
    if (!rst) begin
      if (bus.rd_en != '0) begin
        tests++;
        if (!$onehot(bus.rd_en) || (bus.rd_en & bus.empty) != '0) begin
          fails++;
          $display("FAIL rd_en_legal: rd_en=%b empty=%b, required one-hot on a non-empty channel", bus.rd_en, bus.empty);
        end
      end
      if (bus.dout_vld && bus.dout_rdy) begin
        hs_cyc.push_back(cyc);
        e_c = int'(bus.dout_ch);
        tests++;
        if (xq[e_c].size() == 0) begin
          fails++;
          $display("FAIL sb_data: ch%0d got %h, required no word", e_c, bus.dout);
        end else begin
          e_w = xq[e_c].pop_front();
          if (bus.dout !== e_w) begin
            fails++;
            $display("FAIL sb_data: ch%0d got %h, required %h", e_c, bus.dout, e_w);
          end
        end
        if (och.size() > 0) begin
          tests++;
          e_c = och.pop_front();
          if (int'(bus.dout_ch) != e_c) begin
            fails++;
            $display("FAIL sb_order: dout_ch got %0d, required %0d", bus.dout_ch, e_c);
          end
        end
      end
    end
  end
  initial begin
    logic [DW-1:0] d0;
    logic [CHW-1:0] c0;
    int bad;
    int gexp [7];
    bus.dout_rdy = 1'b1;
    bus.empty = '1;
    bus.din = '0;
    // single channel, latency and return to idle
    do_reset();
    @(negedge clk);
    load(2, 8'hA1); load(2, 8'hB2); load(2, 8'hC3);
    och = '{2, 2, 2};
    #3 chk("lat_idle_rd", bus.rd_en, 4'b0000);
    @(negedge clk); #3;
    chk("lat_rd", bus.rd_en, 4'b0100); chk("lat_busy", bus.busy, 1);
    @(negedge clk); #3;
    chk("lat_vld", bus.dout_vld, 1); chk("w1_dout", bus.dout, 8'hA1); chk("w1_ch", bus.dout_ch, 2);
    chk("w2_rd", bus.rd_en, 4'b0100);
    @(negedge clk); #3;
    chk("w2_dout", bus.dout, 8'hB2); chk("w3_rd", bus.rd_en, 4'b0100);
    @(negedge clk); #3;
    chk("w3_dout", bus.dout, 8'hC3); chk("empty_rd", bus.rd_en, 4'b0000); chk("empty_busy", bus.busy, 1);
    @(negedge clk); #3;
    chk("idle_busy", bus.busy, 0); chk("idle_vld", bus.dout_vld, 0);
    wait_drain(50);
    chk_sb("sb_single");
    // round robin over four always-full channels
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < 4; i++) begin
          load(c, 8'(c * 16 + r * 4 + i));
          och.push_back(c);
        end
    wait_drain(200);
    chk("rr_words", hs_cyc.size(), 32);
    bad = 0;
    for (int k = 1; k < hs_cyc.size(); k++)
      if (hs_cyc[k] - hs_cyc[k-1] != ((k % 4 == 0) ? 2 : 1)) bad++;
    chk("rr_gaps", bad, 0);
    chk_sb("sb_rr");
    // backpressure mid-burst
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      load(0, 8'(8'hA0 + i));
      och.push_back(0);
    end
    wait_hs(2);
    bus.dout_rdy = 1'b0;
    #3;
    d0 = bus.dout;
    c0 = bus.dout_ch;
    chk("bp_dout0", d0, 8'hA2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #3;
      end
      chk("bp_rd", bus.rd_en, 4'b0000);
      chk("bp_hold", {bus.dout_vld, bus.busy, bus.dout_ch, bus.dout}, {1'b1, 1'b1, c0, d0});
    end
    @(negedge clk);
    bus.dout_rdy = 1'b1;
    wait_drain(100);
    chk("bp_words", hs_cyc.size(), 8);
    gexp = '{1, 6, 1, 2, 1, 1, 1};
    bad = 0;
    for (int k = 1; k < hs_cyc.size() && k < 8; k++)
      if (hs_cyc[k] - hs_cyc[k-1] != gexp[k-1]) bad++;
    chk("bp_gaps", bad, 0);
    chk_sb("sb_bp");
    // search pointer wrap
    do_reset();
    @(negedge clk);
    load(1, 8'h11);
    och = '{1};
    wait_drain(50);
    @(negedge clk);
    load(0, 8'h01); load(3, 8'h33);
    och = '{3, 0};
    wait_drain(50);
    chk_sb("sb_wrap");
    // reset mid-burst, then arbitration restarts at ch0
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) load(1, 8'(8'h50 + i));
    load(2, 8'h60); load(2, 8'h61);
    wait_hs(2);
    do_reset();
    @(negedge clk);
    load(2, 8'h70); load(0, 8'h80);
    och = '{0, 2};
    wait_drain(50);
    chk_sb("sb_rst");
    // randomized empty/ready traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.dout_rdy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, NCH - 1)), 8'($urandom));
    end
    bus.dout_rdy = 1'b1;
    wait_drain(500);
    chk_sb("sb_rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rr_arb.md
FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

Interface — parameters
REQ-001 SHALL have parameter DW, default 8: data width of every channel and of the output.
REQ-002 SHALL have parameter NCH, default 4: number of FWFT FIFO read ports arbitrated; legal range 2..16.
REQ-003 SHALL have parameter CHW, default 2: width of the channel-id field; SHALL satisfy 2**CHW >= NCH, otherwise the module SHALL $display an error and $finish.
REQ-004 SHALL have parameter BURST, default 4: maximum words taken per grant; legal range 1..255, otherwise the module SHALL $display an error and $finish.

Interface — ports
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port empty, input, NCH bits: per-channel FIFO empty flag; bit i belongs to channel i.
REQ-008 SHALL have port din, input, NCH*DW bits: per-channel FWFT head word; channel i occupies din[i*DW+:DW], valid while empty[i]==0.
REQ-009 SHALL have port rd_en, output, NCH bits: per-channel FIFO read strobe (pop).
REQ-010 SHALL have port dout, output, DW bits: registered output word.
REQ-011 SHALL have port dout_ch, output, CHW bits: channel id of dout.
REQ-012 SHALL have port dout_vld, output, 1 bit: dout/dout_ch valid.
REQ-013 SHALL have port dout_rdy, input, 1 bit: downstream accepts the word when dout_vld && dout_rdy.
REQ-014 SHALL have port busy, output, 1 bit: high while the FSM is in BURST.

Function
REQ-015 FSM SHALL have two states, IDLE and BURST, plus registers grant (CHW), last (CHW) and cnt (8 bits).
REQ-016 In IDLE with any empty[i]==0: grant SHALL become the first non-empty channel searched cyclically from last+1 (wrapping at NCH-1 -> 0); cnt SHALL be set to 0; state SHALL become BURST. In IDLE with all channels empty, the FSM SHALL stay in IDLE.
REQ-017 Define acc = !dout_vld || dout_rdy. rd_en[grant] SHALL equal (state==BURST) && !empty[grant] && acc, combinationally; all other rd_en bits SHALL be 0.
REQ-018 rd_en SHALL never be high for a channel whose empty bit is high, and never for more than one channel in a cycle.
REQ-019 On a cycle with rd_en[grant]==1: dout SHALL load din[grant*DW+:DW], dout_ch SHALL load grant, dout_vld SHALL become 1, and cnt SHALL increment.
REQ-020 On a cycle with acc==1 and no pop, dout_vld SHALL become 0; with acc==0, dout, dout_ch and dout_vld SHALL hold.
REQ-021 BURST SHALL end (-> IDLE, last<=grant) on a pop with cnt==BURST-1, or on a cycle with acc==1 and empty[grant]==1.
REQ-022 While acc==0, BURST SHALL not end and cnt SHALL hold, regardless of empty.
REQ-023 Latency: an empty bit falling in IDLE SHALL give rd_en on the next cycle and dout_vld on the cycle after; sustained throughput SHALL be one word per cycle within a burst, with one arbitration cycle between bursts.
REQ-024 A channel with continuous data SHALL get at most BURST words per grant; every non-empty channel SHALL be served within NCH grants.

Reset
REQ-025 While rst is high: state=IDLE, grant=0, last=NCH-1 (so channel 0 wins first), cnt=0, dout=0, dout_ch=0, dout_vld=0, rd_en=0, busy=0.
REQ-026 rst asserted mid-burst SHALL clear the FSM immediately; a held dout word SHALL be discarded and no pop SHALL occur after reset rises.

Verification
REQ-027 Single channel: ch2 holds 3 words A,B,C, dout_rdy=1, BURST=4 -> rd_en[2] high for 3 consecutive cycles; dout = A,B,C with dout_ch=2; FSM returns to IDLE on the first cycle empty[2]=1.
REQ-028 Round robin: all 4 channels always non-empty, dout_rdy=1 -> dout_ch sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; one bubble between groups of 4.
REQ-029 Backpressure: dout_rdy=0 for 5 cycles mid-burst -> dout and dout_ch stable, rd_en=0, cnt unchanged; the burst resumes when dout_rdy rises, with no word lost or duplicated.
REQ-030 Wrap of the search pointer: last=3, only ch1 non-empty -> grant=1; then last=1, ch0 and ch3 non-empty -> grant=3.
REQ-031 Reset mid-burst: rst pulses after the 2nd word of a burst -> all outputs 0 during rst; after release, arbitration restarts at ch0.
REQ-032 Scoreboard across randomized empty/dout_rdy: per-channel output order matches FIFO order; rd_en is never asserted while empty.
